// File: rtl/mem_stall_ctrl.sv
// MEM-stage access sequencer for a req/ack DRAM port; holds the pipeline via `stop` while an access is in flight.
// Optional request timeout enabled by defining MEM_TIMEOUT_EN.
module mem_stall_ctrl #(
  parameter int DW      = 32,
  parameter int AW      = 32,
  parameter int TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          mem_have_inst,
  input  logic          mem_dram_re,
  input  logic          mem_dram_we,
  input  logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_wdata,
  input  logic          dram_ack,
  input  logic [DW-1:0] dram_rdata,
  output logic          dram_req,
  output logic          dram_wr,
  output logic [AW-1:0] dram_addr,
  output logic [DW-1:0] dram_wdata,
  output logic          stop,
  output logic [DW-1:0] mem_rdata,
  output logic          mem_rdata_vld,
  output logic          mem_err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0] state_reg;
  logic [1:0] state_next;
  logic       access;
  logic       abort;

  assign access = mem_have_inst & (mem_dram_re | mem_dram_we);

`ifdef MEM_TIMEOUT_EN
  localparam int LIMIT = TIMEOUT - 1;
  logic [7:0] cnt_reg;

  // Ack takes priority over expiry in the same cycle.
  assign abort = (state_reg == REQ) & ~dram_ack & ({24'd0, cnt_reg} == LIMIT[31:0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= 8'd0;
    end else if (state_reg == IDLE && access) begin
      cnt_reg <= 8'd0;
    end else if (state_reg == REQ && !dram_ack && cnt_reg != 8'hFF) begin
      cnt_reg <= cnt_reg + 8'd1;
    end
  end
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = TIMEOUT;
  assign abort = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (access) state_next = REQ;
      REQ:     if (dram_ack || abort) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Gated by rst so the freeze releases immediately when an access is abandoned.
  assign stop = ~rst & (((state_reg == IDLE) & access) | (state_reg == REQ));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      dram_req      <= 1'b0;
      dram_wr       <= 1'b0;
      dram_addr     <= '0;
      dram_wdata    <= '0;
      mem_rdata     <= '0;
      mem_rdata_vld <= 1'b0;
      mem_err       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      mem_rdata_vld <= 1'b0;
      mem_err       <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (access) begin
            dram_addr  <= mem_addr;
            dram_wdata <= mem_wdata;
            dram_wr    <= mem_dram_we;
            dram_req   <= 1'b1;
          end
        end
        REQ: begin
          if (dram_ack) begin
            dram_req      <= 1'b0;
            mem_rdata_vld <= 1'b1;
            if (!dram_wr) mem_rdata <= dram_rdata;
          end else if (abort) begin
            dram_req      <= 1'b0;
            mem_rdata_vld <= 1'b1;
            mem_err       <= 1'b1;
            mem_rdata     <= '0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
